// File: rtl/flash_page_sequencer.sv
// Page-level command sequencer in front of the ASMI flash controller.
// Owns the page staging buffer shared with the host register block.
module flash_page_sequencer #(
    parameter int          PAGE_BYTES     = 256,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h1000_0000
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    output logic        cmd_ready,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    input  logic        buf_wr,
    input  logic [7:0]  buf_addr,
    input  logic [7:0]  buf_wdata,
    output logic [7:0]  buf_rdata,
    output logic [23:0] fc_addr,
    output logic [7:0]  fc_datain,
    input  logic [7:0]  fc_dataout,
    output logic        fc_wren,
    output logic        fc_write,
    output logic        fc_shift_bytes,
    output logic        fc_rden,
    output logic        fc_fast_read,
    output logic        fc_read_status,
    output logic        fc_bulk_erase,
    input  logic        fc_busy,
    input  logic        fc_data_valid,
    input  logic        fc_illegal_write,
    input  logic        fc_illegal_erase,
    input  logic [7:0]  fc_status_out
);

    localparam int          IDX_W     = $clog2(PAGE_BYTES);
    localparam int          CNT_W     = IDX_W + 1;
    localparam logic [23:0] PAGE_MASK = 24'(PAGE_BYTES - 1);

    localparam logic [1:0] OP_PROGRAM = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_ERASE   = 2'd2;
    localparam logic [1:0] OP_STATUS  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SHIFT,
        S_PROG,
        S_RD_START,
        S_RD_DATA,
        S_ERASE,
        S_STAT,
        S_WAIT_BUSY,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [23:0]      addr_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      timer;
    logic [7:0]       mem [PAGE_BYTES];

    logic accept, timed, timeout, illegal, err_set, cnt_inc, stat_cap, rd_wr, host_wr;

    assign accept  = (state == S_IDLE) && cmd_valid;
    assign host_wr = (state == S_IDLE) && buf_wr;
    assign timed   = (state == S_SHIFT) || (state == S_RD_DATA) || (state == S_WAIT_BUSY);
    assign timeout = timed && (timer == TIMEOUT_CYCLES - 32'd1);
    assign illegal = ((op_q == OP_PROGRAM) && fc_illegal_write) ||
                     ((op_q == OP_ERASE)   && fc_illegal_erase);
    assign fc_addr = addr_q;

    always_comb begin
        state_nxt      = state;
        err_set        = 1'b0;
        cnt_inc        = 1'b0;
        stat_cap       = 1'b0;
        rd_wr          = 1'b0;
        cmd_ready      = (state == S_IDLE);
        done           = 1'b0;
        fc_datain      = 8'h00;
        fc_wren        = 1'b0;
        fc_write       = 1'b0;
        fc_shift_bytes = 1'b0;
        fc_rden        = 1'b0;
        fc_fast_read   = 1'b0;
        fc_read_status = 1'b0;
        fc_bulk_erase  = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PROGRAM: state_nxt = S_SHIFT;
                        OP_READ:    state_nxt = S_RD_START;
                        OP_ERASE:   state_nxt = S_ERASE;
                        default:    state_nxt = S_STAT;
                    endcase
                end
            end
            S_SHIFT: begin
                if (!fc_busy) begin
                    fc_wren        = 1'b1;
                    fc_shift_bytes = 1'b1;
                    fc_datain      = mem[cnt[IDX_W-1:0]];
                    cnt_inc        = 1'b1;
                    if (cnt == CNT_W'(PAGE_BYTES - 1)) state_nxt = S_PROG;
                end
            end
            S_PROG: begin
                fc_write  = 1'b1;
                fc_wren   = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_RD_START: begin
                fc_fast_read = 1'b1;
                fc_rden      = 1'b1;
                state_nxt    = S_RD_DATA;
            end
            S_RD_DATA: begin
                fc_rden = 1'b1;
                if (fc_data_valid) begin
                    rd_wr   = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt == CNT_W'(PAGE_BYTES - 1)) state_nxt = S_WAIT_BUSY;
                end
            end
            S_ERASE: begin
                fc_bulk_erase = 1'b1;
                fc_wren       = 1'b1;
                state_nxt     = S_WAIT_BUSY;
            end
            S_STAT: begin
                fc_read_status = 1'b1;
                state_nxt      = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // busy is not trustworthy until the controller has had two cycles to raise it
                if ((timer >= 32'd2) && !fc_busy) begin
                    state_nxt = S_DONE;
                    stat_cap  = (op_q == OP_STATUS);
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Errors win over any normal progress made in the same cycle.
        if ((state != S_IDLE) && (state != S_DONE) && (illegal || timeout)) begin
            err_set        = 1'b1;
            state_nxt      = S_DONE;
            cnt_inc        = 1'b0;
            stat_cap       = 1'b0;
            rd_wr          = 1'b0;
            fc_datain      = 8'h00;
            fc_wren        = 1'b0;
            fc_write       = 1'b0;
            fc_shift_bytes = 1'b0;
            fc_rden        = 1'b0;
            fc_fast_read   = 1'b0;
            fc_read_status = 1'b0;
            fc_bulk_erase  = 1'b0;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= OP_PROGRAM;
            addr_q <= 24'h0;
            cnt    <= '0;
            timer  <= 32'h0;
            error  <= 1'b0;
            status <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= cmd_op;
                addr_q <= (cmd_op == OP_STATUS) ? 24'h0 : (cmd_addr & ~PAGE_MASK);
                cnt    <= '0;
                error  <= 1'b0;
            end else begin
                if (cnt_inc) cnt <= cnt + 1'b1;
                if (err_set) error <= 1'b1;
            end
            if (stat_cap) status <= fc_status_out;
            if (state_nxt != state) timer <= 32'h0;
            else if (timed)         timer <= timer + 32'd1;
        end
    end

    // Host writes only while idle, so they never collide with read-data capture.
    always_ff @(posedge clkin) begin
        if (host_wr)    mem[buf_addr[IDX_W-1:0]] <= buf_wdata;
        else if (rd_wr) mem[cnt[IDX_W-1:0]]      <= fc_dataout;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) buf_rdata <= 8'h00;
        else       buf_rdata <= mem[buf_addr[IDX_W-1:0]];
    end

endmodule

// File: tb/tb_flash_page_sequencer.sv
// Directed bench for flash_page_sequencer: buffer vector table plus
// hand-written program/read/status/erase/timeout/reset sequences.
module tb_flash_page_sequencer;

    logic        clkin = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_valid2;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic        buf_wr, buf_wr2;
    logic [7:0]  buf_addr, buf_wdata;
    logic [7:0]  fc_dataout, fc_status_out;
    logic        fc_busy, fc_busy2, fc_data_valid, fc_illegal_write, fc_illegal_erase;

    logic        cmd_ready, done, error;
    logic [7:0]  status, buf_rdata, fc_datain;
    logic [23:0] fc_addr;
    logic        fc_wren, fc_write, fc_shift_bytes, fc_rden, fc_fast_read, fc_read_status, fc_bulk_erase;

    logic        cmd_ready2, done2, error2;
    logic [7:0]  status2, buf_rdata2, fc_datain2;
    logic [23:0] fc_addr2;
    logic        fc_wren2, fc_write2, fc_shift_bytes2, fc_rden2, fc_fast_read2, fc_read_status2, fc_bulk_erase2;

    logic [6:0] strb, strb2;
    assign strb  = {fc_wren, fc_write, fc_shift_bytes, fc_rden, fc_fast_read, fc_read_status, fc_bulk_erase};
    assign strb2 = {fc_wren2, fc_write2, fc_shift_bytes2, fc_rden2, fc_fast_read2, fc_read_status2, fc_bulk_erase2};

    always #5 clkin = ~clkin;

    flash_page_sequencer dut (
        .clkin(clkin), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_ready(cmd_ready), .done(done), .error(error), .status(status),
        .buf_wr(buf_wr), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .fc_addr(fc_addr), .fc_datain(fc_datain), .fc_dataout(fc_dataout),
        .fc_wren(fc_wren), .fc_write(fc_write), .fc_shift_bytes(fc_shift_bytes), .fc_rden(fc_rden),
        .fc_fast_read(fc_fast_read), .fc_read_status(fc_read_status), .fc_bulk_erase(fc_bulk_erase),
        .fc_busy(fc_busy), .fc_data_valid(fc_data_valid), .fc_illegal_write(fc_illegal_write),
        .fc_illegal_erase(fc_illegal_erase), .fc_status_out(fc_status_out)
    );

    flash_page_sequencer #(.PAGE_BYTES(16), .TIMEOUT_CYCLES(32'd64)) dut_to (
        .clkin(clkin), .reset(reset), .cmd_valid(cmd_valid2), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_ready(cmd_ready2), .done(done2), .error(error2), .status(status2),
        .buf_wr(buf_wr2), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata2),
        .fc_addr(fc_addr2), .fc_datain(fc_datain2), .fc_dataout(fc_dataout),
        .fc_wren(fc_wren2), .fc_write(fc_write2), .fc_shift_bytes(fc_shift_bytes2), .fc_rden(fc_rden2),
        .fc_fast_read(fc_fast_read2), .fc_read_status(fc_read_status2), .fc_bulk_erase(fc_bulk_erase2),
        .fc_busy(fc_busy2), .fc_data_valid(fc_data_valid), .fc_illegal_write(fc_illegal_write),
        .fc_illegal_erase(fc_illegal_erase), .fc_status_out(fc_status_out)
    );

    int tests = 0;
    int fails = 0;

    // Strobe observer, sampled mid-cycle.
    int          shift_n = 0;
    int          write_n = 0;
    int          fr_n    = 0;
    int          done_n  = 0;
    logic [7:0]  shift_log [256];
    logic [23:0] write_addr = 24'h0;

    always @(negedge clkin) begin
        if (fc_shift_bytes) begin
            if (shift_n < 256) shift_log[shift_n] <= fc_datain;
            shift_n <= shift_n + 1;
        end
        if (fc_write) begin
            write_n    <= write_n + 1;
            write_addr <= fc_addr;
        end
        if (fc_fast_read) fr_n <= fr_n + 1;
        if (done) done_n <= done_n + 1;
    end

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp;
    } buf_vec_t;

    buf_vec_t vecs [8];

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  wb, db, fb, bad, rdy_bad, c;
        bit  seen;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_op = 2'd0; cmd_addr = 24'h0;
        buf_wr = 1'b0; buf_wr2 = 1'b0; buf_addr = 8'h0; buf_wdata = 8'h0;
        fc_dataout = 8'h0; fc_status_out = 8'h0;
        fc_busy = 1'b0; fc_busy2 = 1'b0; fc_data_valid = 1'b0;
        fc_illegal_write = 1'b0; fc_illegal_erase = 1'b0;

        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_done",      32'(done),      32'd0);
        check("rst_error",     32'(error),     32'd0);
        check("rst_status",    32'(status),    32'd0);
        check("rst_buf_rdata", 32'(buf_rdata), 32'd0);
        check("rst_strobes",   32'(strb),      32'd0);
        check("rst_fc_addr",   32'(fc_addr),   32'd0);
        check("rst_fc_datain", 32'(fc_datain), 32'd0);
        @(negedge clkin);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 256; i++) begin
            buf_wr = 1'b1; buf_addr = 8'(i); buf_wdata = 8'(i);
            tick();
        end
        buf_wr = 1'b0;

        vecs[0] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[1] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h7F};
        vecs[2] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'hFF};
        vecs[3] = '{1'b1, 8'h10, 8'h5A, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 8'h10, 8'h00, 1'b1, 8'h5A};
        vecs[5] = '{1'b1, 8'h10, 8'h10, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h10, 8'h00, 1'b1, 8'h10};
        vecs[7] = '{1'b0, 8'h80, 8'h00, 1'b1, 8'h80};
        foreach (vecs[k]) begin
            buf_wr = vecs[k].wr; buf_addr = vecs[k].addr; buf_wdata = vecs[k].wdata;
            tick();
            if (vecs[k].chk) check($sformatf("buf_vec%0d", k), 32'(buf_rdata), 32'(vecs[k].exp));
        end
        buf_wr = 1'b0;

        // PROGRAM 0x012345 with a three-cycle busy stall mid-shift
        wb = write_n; db = done_n;
        cmd_op = 2'd0; cmd_addr = 24'h012345; cmd_valid = 1'b1;
        check("prog_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("prog_ready_busy", 32'(cmd_ready), 32'd0);
        for (c = 0; c < 600; c++) begin
            if (fc_write) break;
            fc_busy = (c >= 100 && c < 103);
            if (c == 50)  check("prog_datain50", 32'(fc_datain), 32'd50);
            if (c == 50)  check("prog_shift_strb", 32'(strb), 32'b1010000);
            if (c == 101) check("prog_hold_strb", 32'(strb), 32'd0);
            tick();
        end
        check("prog_write_seen", 32'(fc_write), 32'd1);
        check("prog_wren", 32'(fc_wren), 32'd1);
        check("prog_fc_addr", 32'(fc_addr), 32'h012300);
        fc_busy = 1'b1;
        repeat (6) tick();
        fc_busy = 1'b0;
        wait_done(10, seen);
        check("prog_done_seen", 32'(seen), 32'd1);
        check("prog_error", 32'(error), 32'd0);
        tick();
        check("prog_done_pulse", 32'(done), 32'd0);
        check("prog_shift_count", 32'(shift_n), 32'd256);
        check("prog_write_count", 32'(write_n - wb), 32'd1);
        check("prog_write_addr", 32'(write_addr), 32'h012300);
        check("prog_done_count", 32'(done_n - db), 32'd1);
        bad = 0;
        for (int i = 0; i < 256; i++) if (shift_log[i] !== 8'(i)) bad++;
        check("prog_shift_order", 32'(bad), 32'd0);

        // READ 0x020077, model returns i ^ 0xA5 with occasional gaps
        fb = fr_n; db = done_n;
        cmd_op = 2'd1; cmd_addr = 24'h020077; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("rd_start_strb", 32'(strb), 32'b0001100);
        check("rd_fc_addr", 32'(fc_addr), 32'h020000);
        tick();
        for (int i = 0; i < 256; i++) begin
            if (i % 37 == 5) begin
                fc_data_valid = 1'b0;
                tick();
            end
            fc_data_valid = 1'b1; fc_dataout = 8'(i) ^ 8'hA5;
            if (i == 128) check("rd_rden_mid", 32'(fc_rden), 32'd1);
            tick();
        end
        fc_data_valid = 1'b0;
        check("rd_rden_dropped", 32'(fc_rden), 32'd0);
        wait_done(10, seen);
        check("rd_done_seen", 32'(seen), 32'd1);
        tick();
        buf_addr = 8'h10;
        tick();
        check("rd_buf10", 32'(buf_rdata), 32'hB5);
        buf_addr = 8'hFF;
        tick();
        check("rd_bufFF", 32'(buf_rdata), 32'h5A);
        check("rd_fast_read_count", 32'(fr_n - fb), 32'd1);
        check("rd_done_count", 32'(done_n - db), 32'd1);

        // STATUS with 0x03
        db = done_n; rdy_bad = 0;
        fc_status_out = 8'h03; cmd_op = 2'd3; cmd_addr = 24'h0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (cmd_ready) rdy_bad++;
            tick();
        end
        check("st_done_seen", 32'(seen), 32'd1);
        check("st_ready_low", 32'(rdy_bad), 32'd0);
        check("st_status", 32'(status), 32'h03);
        tick();
        check("st_done_pulse", 32'(done), 32'd0);
        check("st_ready_back", 32'(cmd_ready), 32'd1);
        check("st_done_count", 32'(done_n - db), 32'd1);

        // ERASE with illegal_erase two cycles after the strobe
        fc_status_out = 8'h80; cmd_op = 2'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("er_strobe", 32'(strb), 32'b1000001);
        fc_busy = 1'b1;
        tick();
        tick();
        fc_illegal_erase = 1'b1;
        check("er_error_pre", 32'(error), 32'd0);
        tick();
        check("er_done", 32'(done), 32'd1);
        check("er_error", 32'(error), 32'd1);
        check("er_strobes_low", 32'(strb), 32'd0);
        fc_illegal_erase = 1'b0; fc_busy = 1'b0;
        tick();
        check("er_error_sticky", 32'(error), 32'd1);
        check("er_status_kept", 32'(status), 32'h03);

        // STATUS clears error; illegal_write is irrelevant to STATUS
        fc_status_out = 8'h42; fc_illegal_write = 1'b1; cmd_op = 2'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("clr_error", 32'(error), 32'd0);
        wait_done(10, seen);
        check("clr_done_seen", 32'(seen), 32'd1);
        check("clr_error_done", 32'(error), 32'd0);
        check("clr_status", 32'(status), 32'h42);
        fc_illegal_write = 1'b0;
        tick();

        // Timeout: 16-byte page, 64-cycle limit, busy stuck after program
        buf_addr = 8'h05; buf_wdata = 8'h11; buf_wr2 = 1'b1;
        tick();
        buf_wr2 = 1'b0;
        cmd_op = 2'd0; cmd_addr = 24'h0; cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (fc_write2) break;
            tick();
        end
        check("to_write_seen", 32'(fc_write2), 32'd1);
        fc_busy2 = 1'b1; buf_wdata = 8'h99; buf_wr2 = 1'b1;
        tick();
        buf_wr2 = 1'b0;
        repeat (63) tick();
        check("to_error_before", 32'(error2), 32'd0);
        check("to_done_before", 32'(done2), 32'd0);
        tick();
        check("to_error", 32'(error2), 32'd1);
        check("to_done", 32'(done2), 32'd1);
        check("to_strobes_low", 32'(strb2), 32'd0);
        fc_busy2 = 1'b0;
        tick();
        check("to_ready", 32'(cmd_ready2), 32'd1);
        tick();
        check("to_buf_unchanged", 32'(buf_rdata2), 32'h11);

        // Reset during RD_DATA at byte 100
        cmd_op = 2'd1; cmd_addr = 24'h030000; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            fc_data_valid = 1'b1; fc_dataout = 8'(i) ^ 8'h3C;
            tick();
        end
        fc_data_valid = 1'b0;
        check("rr_rden_before", 32'(fc_rden), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rr_strobes_async", 32'(strb), 32'd0);
        check("rr_fc_addr_async", 32'(fc_addr), 32'd0);
        check("rr_ready_async", 32'(cmd_ready), 32'd1);
        tick();
        #3 reset = 1'b0;
        tick();
        check("rr_ready_after", 32'(cmd_ready), 32'd1);
        check("rr_status_after", 32'(status), 32'd0);
        buf_addr = 8'd0;
        tick();
        check("rr_buf0", 32'(buf_rdata), 32'h3C);
        buf_addr = 8'd99;
        tick();
        check("rr_buf99", 32'(buf_rdata), 32'(8'd99 ^ 8'h3C));
        buf_addr = 8'd100;
        tick();
        check("rr_buf100", 32'(buf_rdata), 32'(8'd100 ^ 8'hA5));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flash_page_sequencer.md
Name: flash_page_sequencer

Overview:
- Sequences the ASMI flash controller for page-level operations requested by the slow-control register block: page program, page read, bulk erase, and status read.
- Owns a PAGE_BYTES staging buffer. The host fills it before a program and reads it back after a read.
- Sits between the register interface and the flash controller. It is the only driver of the controller's command inputs.

Parameters:
- PAGE_BYTES, 256: bytes per program/read transaction. Power of two, ≤256.
- TIMEOUT_CYCLES, 32'h1000_0000: maximum clkin cycles to wait for fc_busy low or for all read bytes. Exceeding it raises error.

Ports:
- clkin  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_op  in  2  0=PROGRAM, 1=READ, 2=ERASE, 3=STATUS
- cmd_addr  in  24  byte address; low log2(PAGE_BYTES) bits ignored for PROGRAM/READ
- cmd_ready  out  1  high in IDLE only; command accepted on cmd_valid&cmd_ready
- done  out  1  one-cycle pulse at command completion
- error  out  1  sticky; set by illegal_write/illegal_erase/timeout; cleared on next accepted command
- status  out  8  last flash status byte
- buf_wr  in  1  host buffer write strobe
- buf_addr  in  8  host buffer index
- buf_wdata  in  8  host write data
- buf_rdata  out  8  buffer[buf_addr], registered, 1-cycle latency
- fc_addr  out  24  to controller addr
- fc_datain  out  8  to controller datain
- fc_dataout  in  8  from controller dataout
- fc_wren, fc_write, fc_shift_bytes, fc_rden, fc_fast_read, fc_read_status, fc_bulk_erase  out  1 each  controller strobes
- fc_busy, fc_data_valid, fc_illegal_write, fc_illegal_erase  in  1 each
- fc_status_out  in  8

Behaviour:
- Reset values: all fc_* outputs 0, done=0, error=0, status=0, buf_rdata=0, cmd_ready=1, state IDLE, byte counter 0, timer 0. Buffer contents are not reset.
- Host buffer port:
  - buf_wr writes are honoured only while cmd_ready=1 and are ignored otherwise.
  - buf_rdata is valid in any state.
- States: IDLE, SHIFT, PROG, RD_START, RD_DATA, ERASE, STAT, WAIT_BUSY, DONE.
- IDLE: on cmd_valid, latch the op and the page-aligned address (status uses none), clear error and the counter, then branch:
  - PROGRAM → SHIFT
  - READ → RD_START
  - ERASE → ERASE
  - STATUS → STAT
- SHIFT:
  - Each cycle with fc_busy=0: assert fc_wren=1 and fc_shift_bytes=1, fc_datain=buffer[cnt], cnt++.
  - When fc_busy=1, hold strobes low and hold cnt.
  - After byte PAGE_BYTES-1 is shifted → PROG.
- PROG: one cycle fc_write=1, fc_wren=1, fc_addr=page address → WAIT_BUSY.
- RD_START:
  - One cycle fc_fast_read=1, fc_rden=1, fc_addr=page address.
  - fc_rden stays 1 through RD_DATA.
- RD_DATA:
  - Each fc_data_valid writes fc_dataout to buffer[cnt], cnt++.
  - When cnt reaches PAGE_BYTES, drop fc_rden → WAIT_BUSY.
- ERASE: one cycle fc_bulk_erase=1, fc_wren=1 → WAIT_BUSY.
- STAT: one cycle fc_read_status=1 → WAIT_BUSY; status captured at exit.
- WAIT_BUSY:
  - Ignore fc_busy for the first 2 cycles (controller assertion latency).
  - Then wait for fc_busy=0.
  - On exit, status<=fc_status_out if op=STATUS → DONE.
- DONE: done=1 for one cycle → IDLE.
- Errors:
  - fc_illegal_write (PROGRAM) or fc_illegal_erase (ERASE) sampled high in any non-IDLE state sets error and jumps to DONE.
  - Timer: resets on state entry; counts in SHIFT, RD_DATA, and WAIT_BUSY. Reaching TIMEOUT_CYCLES sets error, clears all strobes, → DONE.
  - Timeout in RD_DATA leaves the remaining buffer bytes unchanged.
- Simultaneous events: host buf_wr and a read-data write to the same index cannot collide, since the host port is blocked when not IDLE. Error takes priority over normal completion in the same cycle.
- reset mid-operation: immediate return to the reset values. The flash controller is not separately reset by this block.
- Counter is log2(PAGE_BYTES)+1 bits so it can reach PAGE_BYTES without wrapping.

Test Plan:
- Fill buffer with 0x00..0xFF, PROGRAM addr 0x012345 → fc_addr=0x012300 on the fc_write cycle; 256 shift_bytes pulses carrying 0x00..0xFF in order; done after fc_busy falls; error=0.
- READ addr 0x020000 with model returning byte i = i^0xA5 → buf_rdata at index 0x10 reads 0xB5 one cycle after buf_addr=0x10; exactly one fc_fast_read pulse.
- STATUS with fc_status_out=0x03 → status=0x03 and one done pulse; cmd_ready=0 from acceptance until done.
- ERASE with fc_illegal_erase=1 two cycles after the strobe → error=1, done pulse, fc_* strobes low. A following STATUS command clears error.
- PROGRAM with fc_busy held high forever (TIMEOUT_CYCLES=64) → error=1 after 64 cycles in WAIT_BUSY. buf_wr issued during the command leaves buffer unchanged.
- Assert reset during RD_DATA at byte 100 → all fc_* outputs 0 asynchronously; cmd_ready=1 after release; buffer bytes 0..99 retained.
